// File: rtl/rpg_pkg.sv
// Shared playfield constants, arrow direction codes, controller states and
// helpers for the 20-bit {hpos, vpos} position word.
package rpg_pkg;

  localparam int PF_UP    = 31;
  localparam int PF_DOWN  = 510;
  localparam int PF_LEFT  = 144;
  localparam int PF_RIGHT = 783;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_FLY    = 3'd4
  } state_t;

  function automatic logic [9:0] pos_h(input logic [19:0] p);
    return p[19:10];
  endfunction

  function automatic logic [9:0] pos_v(input logic [19:0] p);
    return p[9:0];
  endfunction

  function automatic logic [19:0] pos_pack(input logic [9:0] h, input logic [9:0] v);
    return {h, v};
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Round-robin finder: first alive ranger strictly after `last`, wrapping 5 -> 1.
module rr_pick5 (
  input  logic [4:0] ranger_alive,
  input  logic [2:0] last,
  output logic [2:0] idx,
  output logic       found
);

  logic [2:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= 5; k++) begin
      cand = 3'(((int'(last) + k - 1) % 5) + 1);
      if (!found && ranger_alive[cand - 3'd1]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ranger_arrow_ctrl.sv
// Launches one arrow at a time from a round-robin alive ranger toward the
// player, moves it on move ticks and retires it on playfield exit or hit.
module ranger_arrow_ctrl
  import rpg_pkg::*;
#(
  parameter int STEP        = 4,
  parameter int HIT_R       = 8,
  parameter int UP_BOUND    = PF_UP,
  parameter int DOWN_BOUND  = PF_DOWN,
  parameter int LEFT_BOUND  = PF_LEFT,
  parameter int RIGHT_BOUND = PF_RIGHT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fire_tick,
  input  logic        move_tick,
  input  logic [4:0]  ranger_alive,
  input  logic [19:0] player_pos,
  input  logic [19:0] ranger_pos,
  output logic [2:0]  ranger_num,
  output logic        arrow_active,
  output logic [19:0] arrow_pos,
  output logic [1:0]  arrow_dir,
  output logic        hit
);

  state_t      state_q, state_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  ranger_num_q, ranger_num_d;
  logic [19:0] rpos_q, rpos_d;
  logic [19:0] ppos_q, ppos_d;
  logic        arrow_active_q, arrow_active_d;
  logic [19:0] arrow_pos_q, arrow_pos_d;
  logic [1:0]  arrow_dir_q, arrow_dir_d;
  logic        hit_q, hit_d;

  logic [2:0]  pick_idx;
  logic        pick_found;

  rr_pick5 u_pick (
    .ranger_alive (ranger_alive),
    .last         (last_q),
    .idx          (pick_idx),
    .found        (pick_found)
  );

  // Launch direction from captured ranger/player positions; ties go vertical.
  logic [10:0] dx, dy, adx, ady;
  logic [1:0]  launch_dir;

  always_comb begin
    dx  = {1'b0, pos_h(ppos_q)} - {1'b0, pos_h(rpos_q)};
    dy  = {1'b0, pos_v(ppos_q)} - {1'b0, pos_v(rpos_q)};
    adx = dx[10] ? (11'd0 - dx) : dx;
    ady = dy[10] ? (11'd0 - dy) : dy;
    if (ady >= adx) launch_dir = dy[10] ? DIR_UP : DIR_DOWN;
    else            launch_dir = dx[10] ? DIR_LEFT : DIR_RIGHT;
  end

  // Next arrow position at 11 bits so the bound compare sees overshoot.
  logic [10:0] cur_h, cur_v, nxt_h, nxt_v, dh, dv, adh, adv;
  logic        out_of_bounds, hit_now;

  always_comb begin
    cur_h = {1'b0, pos_h(arrow_pos_q)};
    cur_v = {1'b0, pos_v(arrow_pos_q)};
    nxt_h = cur_h;
    nxt_v = cur_v;
    case (arrow_dir_q)
      DIR_UP:    nxt_v = cur_v - 11'(STEP);
      DIR_DOWN:  nxt_v = cur_v + 11'(STEP);
      DIR_LEFT:  nxt_h = cur_h - 11'(STEP);
      default:   nxt_h = cur_h + 11'(STEP);
    endcase
    out_of_bounds = (nxt_v < 11'(UP_BOUND))   || (nxt_v > 11'(DOWN_BOUND)) ||
                    (nxt_h < 11'(LEFT_BOUND)) || (nxt_h > 11'(RIGHT_BOUND));
    dh  = nxt_h - {1'b0, pos_h(player_pos)};
    dv  = nxt_v - {1'b0, pos_v(player_pos)};
    adh = dh[10] ? (11'd0 - dh) : dh;
    adv = dv[10] ? (11'd0 - dv) : dv;
    hit_now = (adh < 11'(HIT_R)) && (adv < 11'(HIT_R));
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    ranger_num_d   = ranger_num_q;
    rpos_d         = rpos_q;
    ppos_d         = ppos_q;
    arrow_active_d = arrow_active_q;
    arrow_pos_d    = arrow_pos_q;
    arrow_dir_d    = arrow_dir_q;
    hit_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_tick && pick_found) begin
          ranger_num_d = pick_idx;
          last_d       = pick_idx;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        rpos_d  = ranger_pos;
        ppos_d  = player_pos;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        arrow_pos_d    = rpos_q;
        arrow_dir_d    = launch_dir;
        arrow_active_d = 1'b1;
        ranger_num_d   = 3'd0;
        state_d        = ST_FLY;
      end
      ST_FLY: begin
        if (move_tick) begin
          // Bounds win over a hit on the same move.
          if (out_of_bounds) begin
            arrow_active_d = 1'b0;
            state_d        = ST_IDLE;
          end else begin
            arrow_pos_d = pos_pack(nxt_h[9:0], nxt_v[9:0]);
            if (hit_now) begin
              hit_d          = 1'b1;
              arrow_active_d = 1'b0;
              state_d        = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_q         <= 3'd5;
      ranger_num_q   <= 3'd0;
      rpos_q         <= '0;
      ppos_q         <= '0;
      arrow_active_q <= 1'b0;
      arrow_pos_q    <= '0;
      arrow_dir_q    <= 2'd0;
      hit_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      ranger_num_q   <= ranger_num_d;
      rpos_q         <= rpos_d;
      ppos_q         <= ppos_d;
      arrow_active_q <= arrow_active_d;
      arrow_pos_q    <= arrow_pos_d;
      arrow_dir_q    <= arrow_dir_d;
      hit_q          <= hit_d;
    end
  end

  assign ranger_num   = ranger_num_q;
  assign arrow_active = arrow_active_q;
  assign arrow_pos    = arrow_pos_q;
  assign arrow_dir    = arrow_dir_q;
  assign hit          = hit_q;

endmodule
